// File: rtl/ifm_buf_reader_if.sv
// ifm_buf_reader_if: tile control, buffer read port and output stream of the ifm buffer reader
interface ifm_buf_reader_if #(
  parameter int ADDR_BIT = 15,
  parameter int DIM_BIT  = 8
);
  logic                start;
  logic [ADDR_BIT-2:0] base_addr;
  logic [ADDR_BIT-2:0] row_stride;
  logic [DIM_BIT-1:0]  num_rows;
  logic [DIM_BIT-1:0]  num_cols;
  logic [ADDR_BIT-2:0] bram_addr_read;
  logic [3:0]          ifmstream_0;
  logic [3:0]          ifmstream_1;
  logic [3:0]          ifmstream_2;
  logic [3:0]          ifmstream_3;
  logic [3:0]          ifmstream_4;
  logic [3:0]          ifmstream_5;
  logic [3:0]          ifmstream_6;
  logic [3:0]          ifmstream_7;
  logic [31:0]         out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;
  modport slave (
    input  start, base_addr, row_stride, num_rows, num_cols,
    input  ifmstream_0, ifmstream_1, ifmstream_2, ifmstream_3,
    input  ifmstream_4, ifmstream_5, ifmstream_6, ifmstream_7, out_ready,
    output bram_addr_read, out_data, out_valid, out_last, busy, done
  );
  modport master (
    output start, base_addr, row_stride, num_rows, num_cols,
    output ifmstream_0, ifmstream_1, ifmstream_2, ifmstream_3,
    output ifmstream_4, ifmstream_5, ifmstream_6, ifmstream_7, out_ready,
    input  bram_addr_read, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/ifm_buf_reader.sv
// ifm_buf_reader: streams one tile out of the ifm buffer in row-major order
// through a 2-entry FIFO that hides the one-cycle buffer read latency.
module ifm_buf_reader #(
  parameter int ADDR_BIT = 15,
  parameter int DIM_BIT  = 8
) (
  input logic           clk,
  input logic           rst_n,
  ifm_buf_reader_if.slave bus
);
  localparam int AW = ADDR_BIT - 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d, last_addr_q, last_addr_d;
  logic [DIM_BIT-1:0] rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d;
  logic [1:0][31:0] mem_q, mem_d;
  logic [1:0] mem_last_q, mem_last_d, occ_q, occ_d, fill;
  logic wr_q, wr_d, rd_q, rd_d, infl_q, infl_d, infl_last_q, infl_last_d;
  logic all_q, all_d, zero_q, zero_d;
  logic idle, start_ok, empty_tile, issue, pop, col_end, end_pt, tile_done;
  logic [AW-1:0] a_cur, rb_cur, st_cur;
  logic [DIM_BIT-1:0] r_cur, c_cur, rows_cur, cols_cur;
  logic [31:0] lanes;
  assign lanes = {bus.ifmstream_7, bus.ifmstream_6, bus.ifmstream_5, bus.ifmstream_4,
                  bus.ifmstream_3, bus.ifmstream_2, bus.ifmstream_1, bus.ifmstream_0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (idle && issue) ? ISSUE :
              (state_q == ISSUE && (all_q || (issue && end_pt))) ? DRAIN :
              tile_done ? IDLE : state_q;
  // The first address goes out in the start cycle itself, straight from the
  // tile inputs, so the first beat is ready two cycles later.
  always_comb begin
    idle = state_q == IDLE;
    start_ok = idle && bus.start && rst_n;
    empty_tile = bus.num_rows == '0 || bus.num_cols == '0;
    a_cur = idle ? bus.base_addr : addr_q;
    rb_cur = idle ? bus.base_addr : row_base_q;
    st_cur = idle ? bus.row_stride : stride_q;
    r_cur = idle ? '0 : r_q;
    c_cur = idle ? '0 : c_q;
    rows_cur = idle ? bus.num_rows : rows_q;
    cols_cur = idle ? bus.num_cols : cols_q;
    col_end = c_cur + DIM_BIT'(1) == cols_cur;
    end_pt = col_end && (r_cur + DIM_BIT'(1) == rows_cur);
    pop = occ_q != 2'd0 && bus.out_ready;
    fill = occ_q + {1'b0, infl_q} - {1'b0, pop};
    issue = (start_ok && !empty_tile) || (state_q == ISSUE && !all_q && fill < 2'd2);
    bus.out_valid = occ_q != 2'd0;
    bus.out_data = mem_q[rd_q];
    bus.out_last = bus.out_valid && mem_last_q[rd_q];
    tile_done = state_q == DRAIN && pop && bus.out_last;
    bus.busy = !idle;
    bus.done = zero_q || tile_done;
    bus.bram_addr_read = issue ? a_cur : last_addr_q;
  end
  always_comb begin
    addr_d = addr_q;
    row_base_d = row_base_q;
    stride_d = start_ok ? bus.row_stride : stride_q;
    rows_d = start_ok ? bus.num_rows : rows_q;
    cols_d = start_ok ? bus.num_cols : cols_q;
    r_d = r_q;
    c_d = c_q;
    last_addr_d = last_addr_q;
    infl_last_d = infl_last_q;
    all_d = all_q;
    if (issue) begin
      last_addr_d = a_cur;
      infl_last_d = end_pt;
      all_d = end_pt;
      c_d = col_end ? '0 : c_cur + DIM_BIT'(1);
      r_d = col_end ? r_cur + DIM_BIT'(1) : r_cur;
      row_base_d = col_end ? rb_cur + st_cur : rb_cur;
      addr_d = col_end ? rb_cur + st_cur : a_cur + AW'(1);
    end
    infl_d = issue;
    zero_d = start_ok && empty_tile;
    mem_d = mem_q;
    mem_last_d = mem_last_q;
    if (infl_q) begin
      mem_d[wr_q] = lanes;
      mem_last_d[wr_q] = infl_last_q;
    end
    wr_d = wr_q ^ infl_q;
    rd_d = rd_q ^ pop;
    occ_d = fill;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      row_base_q <= '0;
      stride_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      r_q <= '0;
      c_q <= '0;
      last_addr_q <= '0;
      infl_last_q <= 1'b0;
      all_q <= 1'b0;
      infl_q <= 1'b0;
      zero_q <= 1'b0;
      mem_q <= '0;
      mem_last_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      occ_q <= '0;
    end else begin
      addr_q <= addr_d;
      row_base_q <= row_base_d;
      stride_q <= stride_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      r_q <= r_d;
      c_q <= c_d;
      last_addr_q <= last_addr_d;
      infl_last_q <= infl_last_d;
      all_q <= all_d;
      infl_q <= infl_d;
      zero_q <= zero_d;
      mem_q <= mem_d;
      mem_last_q <= mem_last_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
endmodule

// File: tb/tb_ifm_buf_reader.sv
// tb_ifm_buf_reader: random and directed tiles checked against a row-major beat-list model
module tb_ifm_buf_reader;
  localparam int AB = 15, DB = 8, AW = 14;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ifm_buf_reader_if #(.ADDR_BIT(AB), .DIM_BIT(DB)) bus();
  ifm_buf_reader #(.ADDR_BIT(AB), .DIM_BIT(DB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  beat_t q[$];
  int cyc = 0, compared = 0, mismatched = 0, pc = 0, rdy_mode = 0;
  logic mode = 1'b0;
  logic exp_busy = 1'b0, zero_pend = 1'b0, stall_prev = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_d = '0, lane_w;
  int log_cyc[$], done_cyc[$];
  logic [31:0] log_d[$];
  logic log_l[$];
  // mode 1 encodes the full address in the word so wrong addresses show up as wrong data
  function automatic logic [31:0] word(input logic m, input logic [AW-1:0] a);
    return m ? {a ^ 14'h2A5A, 2'b10, a, 2'b01} : {8{a[3:0]}};
  endfunction
  always @(posedge clk) lane_w <= word(mode, bus.bram_addr_read);
  assign bus.ifmstream_0 = lane_w[3:0];
  assign bus.ifmstream_1 = lane_w[7:4];
  assign bus.ifmstream_2 = lane_w[11:8];
  assign bus.ifmstream_3 = lane_w[15:12];
  assign bus.ifmstream_4 = lane_w[19:16];
  assign bus.ifmstream_5 = lane_w[23:20];
  assign bus.ifmstream_6 = lane_w[27:24];
  assign bus.ifmstream_7 = lane_w[31:28];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic exp_done, nb;
    beat_t b;
    if (!rst_n) begin
      chk("reset_outs", {bus.bram_addr_read, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done}, '0);
      q.delete();
      exp_busy = 1'b0;
      zero_pend = 1'b0;
      stall_prev = 1'b0;
    end else begin
      exp_done = zero_pend || (bus.out_valid && bus.out_ready && q.size() != 0 && q[0].l);
      chk("busy", bus.busy, exp_busy);
      chk("done", bus.done, exp_done);
      if (stall_prev) chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, prev_l, prev_d});
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_beat: got data %0h with no beat expected (cycle %0d)", bus.out_data, cyc);
        end else chk("beat", {bus.out_last, bus.out_data}, {q[0].l, q[0].d});
      end else chk("last_idle", bus.out_last, 1'b0);
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        log_cyc.push_back(cyc);
        log_d.push_back(bus.out_data);
        log_l.push_back(bus.out_last);
        void'(q.pop_front());
      end
      if (exp_done) done_cyc.push_back(cyc);
      nb = exp_busy && !exp_done;
      zero_pend = 1'b0;
      if (bus.start && !exp_busy) begin
        if (bus.num_rows == 0 || bus.num_cols == 0) zero_pend = 1'b1;
        else begin
          nb = 1'b1;
          for (int r = 0; r < int'(bus.num_rows); r++)
            for (int c = 0; c < int'(bus.num_cols); c++) begin
              b.d = word(mode, AW'(int'(bus.base_addr) + r * int'(bus.row_stride) + c));
              b.l = (r == int'(bus.num_rows) - 1) && (c == int'(bus.num_cols) - 1);
              q.push_back(b);
            end
        end
      end
      exp_busy = nb;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (pc % 3 == 0) : 1'($urandom_range(0, 1));
    pc++;
  endtask
  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [DB-1:0] r,
                        input logic [DB-1:0] c, output int st);
    bus.base_addr = b;
    bus.row_stride = s;
    bus.num_rows = r;
    bus.num_cols = c;
    bus.start = 1'b1;
    st = cyc;
    tick();
    bus.start = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.row_stride = AW'($urandom);
    bus.num_rows = DB'($urandom);
    bus.num_cols = DB'($urandom);
  endtask
  task automatic wait_idle(input bit inj);
    int n = 0;
    while ((exp_busy || zero_pend || q.size() != 0) && n < 3000) begin
      if (inj && $urandom_range(0, 5) == 0) begin
        bus.num_rows = DB'($urandom_range(0, 3));
        bus.num_cols = DB'($urandom_range(0, 3));
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("FAIL timeout: tile still open after %0d cycles", n);
    end
  endtask
  task automatic clear_logs();
    log_cyc.delete();
    log_d.delete();
    log_l.delete();
    done_cyc.delete();
  endtask
  initial begin
    int st;
    logic [31:0] exp34 [6];
    logic [AW-1:0] a34 [6], awrap [4];
    exp34 = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h00000000, 32'h11111111, 32'h22222222};
    a34 = '{14'h0010, 14'h0011, 14'h0012, 14'h0030, 14'h0031, 14'h0032};
    awrap = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.row_stride = '0;
    bus.num_rows = '0;
    bus.num_cols = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    launch(14'h0010, 14'h0020, 8'd2, 8'd3, st);
    wait_idle(1'b0);
    chk("t34_beats", log_d.size(), 6);
    if (log_d.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t34_data", log_d[i], exp34[i]);
        chk("t34_cycle", log_cyc[i], st + 2 + i);
        chk("t34_last", log_l[i], i == 5);
      end
    chk("t34_done_cycle", done_cyc.size() != 0 ? done_cyc[0] : -1, st + 7);
    mode = 1'b1;
    rdy_mode = 1;
    clear_logs();
    launch(14'h0010, 14'h0020, 8'd2, 8'd3, st);
    wait_idle(1'b0);
    chk("t35_beats", log_d.size(), 6);
    if (log_d.size() == 6)
      for (int i = 0; i < 6; i++) chk("t35_addr", log_d[i][15:2], a34[i]);
    rdy_mode = 0;
    clear_logs();
    launch(14'h3FFE, 14'h0123, 8'd1, 8'd4, st);
    wait_idle(1'b0);
    chk("wrap_beats", log_d.size(), 4);
    if (log_d.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_addr", log_d[i][15:2], awrap[i]);
    clear_logs();
    launch(14'h0200, 14'h0010, 8'd3, 8'd0, st);
    wait_idle(1'b0);
    chk("cols0_done_cycle", done_cyc.size() != 0 ? done_cyc[0] : -1, st + 1);
    chk("cols0_beats", log_d.size(), 0);
    clear_logs();
    launch(14'h0200, 14'h0010, 8'd0, 8'd5, st);
    wait_idle(1'b0);
    chk("rows0_beats", log_d.size(), 0);
    clear_logs();
    launch(14'h0ABC, 14'h0010, 8'd1, 8'd1, st);
    wait_idle(1'b0);
    chk("one_beats", log_d.size(), 1);
    chk("one_beat", {log_l.size() != 0 ? log_l[0] : 1'b0, log_d.size() != 0 ? log_d[0][15:2] : 14'h0}, {1'b1, 14'h0ABC});
    rdy_mode = 2;
    clear_logs();
    launch(14'h0100, 14'h0040, 8'd3, 8'd4, st);
    repeat (3) tick();
    bus.base_addr = 14'h2000;
    bus.num_rows = 8'd2;
    bus.num_cols = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle(1'b0);
    chk("midstart_beats", log_d.size(), 12);
    if (log_d.size() == 12) chk("midstart_ends", {log_d[0][15:2], log_d[11][15:2]}, {14'h0100, 14'h0183});
    launch(14'h0500, 14'h0010, 8'd3, 8'd5, st);
    repeat (6) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    launch(14'h0040, 14'h0008, 8'd2, 8'd2, st);
    wait_idle(1'b0);
    chk("postrst_beats", log_d.size(), 4);
    if (log_d.size() == 4) chk("postrst_last_addr", log_d[3][15:2], 14'h0049);
    for (int t = 0; t < 60; t++) begin
      rdy_mode = int'($urandom_range(0, 2));
      clear_logs();
      launch(AW'($urandom), AW'($urandom_range(1, 16383)), DB'($urandom_range(0, 4)), DB'($urandom_range(0, 5)), st);
      wait_idle(t % 2 == 1);
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ifm_buf_reader.md
IFM_BUF_READER -- requirements
Module: ifm_buf_reader

Interface
REQ-001 Parameter ADDR_BIT, default 15: buffer address width; the read address port is ADDR_BIT-1 bits.
REQ-002 Parameter DIM_BIT, default 8: width of the tile row and column counts.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse; starts one tile read.
REQ-007 base_addr  input  ADDR_BIT-1  address of the first word of the tile.
REQ-008 row_stride  input  ADDR_BIT-1  address increment between tile rows.
REQ-009 num_rows  input  DIM_BIT  tile rows.
REQ-010 num_cols  input  DIM_BIT  words per row.
REQ-011 bram_addr_read  output  ADDR_BIT-1  read address to the ifm buffer.
REQ-012 ifmstream_0..ifmstream_7  input  4 each  buffer read lanes; data arrives 1 cycle after the address.
REQ-013 out_data  output  32  lane k on bits [4k+3:4k].
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 out_last  output  1  marks the final beat of the tile.
REQ-017 busy  output  1  a tile is in progress.
REQ-018 done  output  1  one-cycle pulse when the tile completes.

Function
REQ-019 The FSM SHALL have three states:
- IDLE
- ISSUE
- DRAIN
REQ-020 FSM transitions:
- IDLE->ISSUE on start, latching all four tile inputs.
- ISSUE->DRAIN after the last address is issued.
- DRAIN->IDLE when the last beat is accepted; done is pulsed in that same cycle.
REQ-021 If start arrives with num_rows==0 or num_cols==0, the block SHALL remain IDLE, issue no address and pulse done on the next cycle.
REQ-022 start while busy SHALL be ignored.
REQ-023 Address order SHALL be row-major:
- addr = base_addr + r*row_stride + c, for r in [0,num_rows) and c in [0,num_cols).
- The address is computed incrementally (no multiplier).
- It wraps modulo 2^(ADDR_BIT-1).
REQ-024 An output FIFO of exactly 2 entries SHALL absorb the 1-cycle read latency.
- An address SHALL be issued only if (FIFO occupancy + reads in flight) < 2.
- This guarantees no overflow under any out_ready pattern.
REQ-025 Lanes SHALL be captured into the FIFO only in the cycle after an issue; a captured word is never dropped or duplicated.
REQ-026 When no address is issued, bram_addr_read SHALL hold its last value.
REQ-027 out_valid SHALL equal FIFO non-empty.
- out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
- A beat transfers when out_valid and out_ready are both 1.
REQ-028 A push and a pop in the same cycle SHALL leave occupancy unchanged.
- If the FIFO is full with a pop pending, a new issue is allowed that cycle.
REQ-029 out_last SHALL be 1 only on the beat for r=num_rows-1, c=num_cols-1.
- For a 1x1 tile that is the single beat.
REQ-030 busy SHALL be 1 from the cycle after an accepted start until the cycle done is pulsed, inclusive.
REQ-031 With out_ready held at 1, throughput SHALL be one beat per cycle, and the first out_valid SHALL appear 2 cycles after start.

Reset
REQ-032 While rst_n=0, all of the following SHALL be 0:
- outputs bram_addr_read, out_data, out_valid, out_last, busy and done
- FSM state IDLE
- FIFO occupancy
- the in-flight flag
REQ-033 A reset asserted mid-tile SHALL abandon the tile.
- No done is pulsed.
- FIFO contents are discarded.
- After release, the block is IDLE and accepts a new start.

Verification
REQ-034 Stimulus: base=0x0010, stride=0x0020, rows=2, cols=3, out_ready=1, buffer returns addr[3:0] on every lane.
- Addresses SHALL be 0x10, 0x11, 0x12, 0x30, 0x31, 0x32.
- There SHALL be 6 beats on consecutive cycles.
- out_last SHALL be set on beat 6, and done asserted in the same cycle.
REQ-035 Backpressure: same tile with out_ready toggling 1,0,0,1,...
- Exactly 6 beats in order.
- Occupancy never exceeds 2.
- out_data is stable during stalls.
REQ-036 Wrap: base=0x3FFE (ADDR_BIT=15), rows=1, cols=4.
- Addresses SHALL be 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-037 Degenerate inputs:
- cols=0 -> done 1 cycle after start, no out_valid, busy stays 0.
- A 1x1 tile -> a single beat with out_last=1.
REQ-038 start pulsed again mid-tile -> ignored, tile completes normally.
- rst_n pulsed low mid-tile -> all outputs 0, no done; a following tile runs correctly.
